// File: rtl/hazard_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: forward selects,
// FSM states and the per-stage shadow control record.
package hazard_pkg;

  localparam int          HZ_RA_W = 4;
  localparam logic [3:0]  PC_REG  = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic               valid;
    logic [HZ_RA_W-1:0] ra1;
    logic [HZ_RA_W-1:0] ra2;
    logic [HZ_RA_W-1:0] wa3;
    logic               regwrite;
    logic               memtoreg;
    logic               pcsrc;
    logic               memop;
  } stage_ctl_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one E-stage source register; M result wins over W,
// and the PC register is always read from the register file path.
module hazard_fwd_sel #(
  parameter int RA_W = 4
) (
  input  logic [RA_W-1:0] ra,
  input  logic            m_valid,
  input  logic            m_regwrite,
  input  logic [RA_W-1:0] m_wa3,
  input  logic            w_valid,
  input  logic            w_regwrite,
  input  logic [RA_W-1:0] w_wa3,
  output logic [1:0]      sel
);
  import hazard_pkg::*;

  always_comb begin
    sel = FWD_RF;
    if (ra != PC_REG) begin
      if (m_valid && m_regwrite && (m_wa3 == ra)) begin
        sel = FWD_MEM;
      end else if (w_valid && w_regwrite && (w_wa3 == ra)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_sched_unit.sv
// Pipeline hazard controller: shadows E/M/W control fields and drives stall,
// flush and forward controls (load-use, branch, PC drain, memory wait).
module hazard_sched_unit #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  ra1d,
  input  logic [RA_W-1:0]  ra2d,
  input  logic [RA_W-1:0]  wa3d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             pcsrc_d,
  input  logic             memop_d,
  input  logic             branch_taken_e,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);
  import hazard_pkg::*;

  stage_ctl_t       r_e, r_m, r_w;
  stage_ctl_t       w_d_stage;
  hz_state_t        r_state, r_saved;
  hz_state_t        w_next, w_saved_next, w_cur;
  logic             r_d_bubble;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d_valid;
  logic             w_mem_wait;
  logic             w_lu_hit;
  logic             w_pcsrc_w;

  // D holds a bubble for one cycle after it was flushed (and while it is held).
  assign w_d_valid = !r_d_bubble;

  always_comb begin
    w_d_stage          = '0;
    w_d_stage.valid    = w_d_valid;
    w_d_stage.ra1      = ra1d;
    w_d_stage.ra2      = ra2d;
    w_d_stage.wa3      = wa3d;
    w_d_stage.regwrite = regwrite_d;
    w_d_stage.memtoreg = memtoreg_d;
    w_d_stage.pcsrc    = pcsrc_d;
    w_d_stage.memop    = memop_d;
  end

  assign w_mem_wait = r_m.valid && r_m.memop && !mem_ready;
  assign w_pcsrc_w  = r_w.valid && r_w.pcsrc;
  assign w_lu_hit   = r_e.valid && r_e.memtoreg && w_d_valid &&
                      (((ra1d == r_e.wa3) && (ra1d != PC_REG)) ||
                       ((ra2d == r_e.wa3) && (ra2d != PC_REG)));
  // While waiting on memory, decisions are made on behalf of the saved state.
  assign w_cur = (r_state == MEM_WAIT) ? r_saved : r_state;

  always_comb begin
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_w      = 1'b0;
    w_next       = r_state;
    w_saved_next = r_saved;
    if (!reset) begin
      w_next       = RUN;
      w_saved_next = RUN;
    end else if (w_mem_wait) begin
      stall_f      = 1'b1;
      stall_d      = 1'b1;
      stall_e      = 1'b1;
      stall_m      = 1'b1;
      flush_w      = 1'b1;
      w_next       = MEM_WAIT;
      // The W instruction retires at this edge, so a drain it ends is over.
      w_saved_next = ((w_cur == DRAIN) && w_pcsrc_w) ? RUN : w_cur;
    end else begin
      w_next = w_cur;
      if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (w_lu_hit) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if ((w_cur == RUN) && w_d_valid && pcsrc_d) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        w_next  = DRAIN;
      end
      if (w_cur == DRAIN) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        if (w_pcsrc_w) begin
          w_next = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_saved    <= RUN;
      r_e        <= '0;
      r_m        <= '0;
      r_w        <= '0;
      r_d_bubble <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      r_saved <= w_saved_next;
      if (!stall_d) begin
        r_d_bubble <= flush_d;
      end
      if (!stall_e) begin
        r_e <= flush_e ? '0 : w_d_stage;
      end
      if (!stall_m) begin
        r_m <= r_e;
      end
      r_w <= flush_w ? '0 : r_m;
      if (stall_f && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .ra         (r_e.ra1),
    .m_valid    (r_m.valid),
    .m_regwrite (r_m.regwrite),
    .m_wa3      (r_m.wa3),
    .w_valid    (r_w.valid),
    .w_regwrite (r_w.regwrite),
    .w_wa3      (r_w.wa3),
    .sel        (fwd_a_e)
  );

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .ra         (r_e.ra2),
    .m_valid    (r_m.valid),
    .m_regwrite (r_m.regwrite),
    .m_wa3      (r_m.wa3),
    .w_valid    (r_w.valid),
    .w_regwrite (r_w.regwrite),
    .w_wa3      (r_w.wa3),
    .sel        (fwd_b_e)
  );

  assign stall_cnt = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Directed table of per-cycle stimulus and hand-computed controls for
// hazard_sched_unit, plus counter saturation and asynchronous reset sequences.
module tb_hazard_sched_unit;

  localparam int CW = 4;

  localparam int C_NOP = 4'b0000;
  localparam int C_ALU = 4'b1000;
  localparam int C_LDR = 4'b1101;
  localparam int C_PC  = 4'b1010;
  localparam int C_STR = 4'b0001;

  localparam int V_0   = 7'b0000000;
  localparam int V_LU  = 7'b1100010;
  localparam int V_BR  = 7'b0000110;
  localparam int V_DR  = 7'b1000100;
  localparam int V_MW  = 7'b1111001;

  localparam int S_RUN = 0;
  localparam int S_DR  = 1;
  localparam int S_MW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    ra1d = '0, ra2d = '0, wa3d = '0;
  logic          regwrite_d = 1'b0, memtoreg_d = 1'b0, pcsrc_d = 1'b0, memop_d = 1'b0;
  logic          branch_taken_e = 1'b0;
  logic          mem_ready = 1'b1;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] ra1, ra2, wa3;
    logic [3:0] ctl;
    logic       br, rdy;
    logic [6:0] exp_ctl;
    logic [1:0] exp_fa, exp_fb;
    logic [3:0] exp_cnt;
    logic [1:0] exp_st;
  } vec_t;

  vec_t tbl[$];

  hazard_sched_unit #(.RA_W(4), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ra1d           (ra1d),
    .ra2d           (ra2d),
    .wa3d           (wa3d),
    .regwrite_d     (regwrite_d),
    .memtoreg_d     (memtoreg_d),
    .pcsrc_d        (pcsrc_d),
    .memop_d        (memop_d),
    .branch_taken_e (branch_taken_e),
    .mem_ready      (mem_ready),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_w        (flush_w),
    .fwd_a_e        (fwd_a_e),
    .fwd_b_e        (fwd_b_e),
    .stall_cnt      (stall_cnt),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int r, int a1, int a2, int w, int c, int b, int rd,
                              int ec, int fa, int fb, int cnt, int st);
    vec_t v;
    v.rst_n   = r[0];
    v.ra1     = a1[3:0];
    v.ra2     = a2[3:0];
    v.wa3     = w[3:0];
    v.ctl     = c[3:0];
    v.br      = b[0];
    v.rdy     = rd[0];
    v.exp_ctl = ec[6:0];
    v.exp_fa  = fa[1:0];
    v.exp_fb  = fb[1:0];
    v.exp_cnt = cnt[3:0];
    v.exp_st  = st[1:0];
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reset          = v.rst_n;
    ra1d           = v.ra1;
    ra2d           = v.ra2;
    wa3d           = v.wa3;
    {regwrite_d, memtoreg_d, pcsrc_d, memop_d} = v.ctl;
    branch_taken_e = v.br;
    mem_ready      = v.rdy;
  endtask

  task automatic drive_nop(input logic br, input logic rdy);
    ra1d = '0; ra2d = '0; wa3d = '0;
    {regwrite_d, memtoreg_d, pcsrc_d, memop_d} = 4'b0000;
    branch_taken_e = br;
    mem_ready      = rdy;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_vec();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
  endfunction

  initial begin
    // Fields: rst ra1 ra2 wa3 ctl br rdy | ctl-vector fwd_a fwd_b cnt state
    tbl.push_back(mk(0, 0, 0, 0, C_NOP, 0, 1, V_0,  0, 0, 0, S_RUN)); // 0 reset
    tbl.push_back(mk(1, 0, 0, 1, C_ALU, 0, 1, V_0,  0, 0, 0, S_RUN)); // 1 ADD R1
    tbl.push_back(mk(1, 1, 3, 4, C_ALU, 0, 1, V_0,  0, 0, 0, S_RUN)); // 2 SUB R4,R1,R3
    tbl.push_back(mk(1, 1, 4, 5, C_ALU, 0, 1, V_0,  2, 0, 0, S_RUN)); // 3 R1 from M
    tbl.push_back(mk(1, 0, 0, 15, C_ALU, 0, 1, V_0, 1, 2, 0, S_RUN)); // 4 R1 from W, R4 from M
    tbl.push_back(mk(1, 15, 5, 6, C_NOP, 0, 1, V_0, 0, 0, 0, S_RUN)); // 5
    tbl.push_back(mk(1, 0, 0, 7, C_ALU, 0, 1, V_0,  0, 1, 0, S_RUN)); // 6 R15 never fwd
    tbl.push_back(mk(1, 0, 0, 7, C_ALU, 0, 1, V_0,  0, 0, 0, S_RUN)); // 7
    tbl.push_back(mk(1, 7, 7, 8, C_NOP, 0, 1, V_0,  0, 0, 0, S_RUN)); // 8
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_0,  2, 2, 0, S_RUN)); // 9 M beats W
    tbl.push_back(mk(1, 0, 0, 2, C_LDR, 0, 1, V_0,  0, 0, 0, S_RUN)); // 10 LDR R2
    tbl.push_back(mk(1, 3, 2, 9, C_ALU, 0, 1, V_LU, 0, 0, 0, S_RUN)); // 11 load-use
    tbl.push_back(mk(1, 3, 2, 9, C_ALU, 0, 1, V_0,  0, 0, 1, S_RUN)); // 12 one cycle only
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_0,  0, 1, 1, S_RUN)); // 13 load from W
    tbl.push_back(mk(1, 0, 0, 2, C_LDR, 0, 1, V_0,  0, 0, 1, S_RUN)); // 14 LDR R2
    tbl.push_back(mk(1, 0, 2, 10, C_ALU, 1, 1, V_BR, 0, 0, 1, S_RUN)); // 15 branch wins
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_0,  0, 0, 1, S_RUN)); // 16
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_0,  0, 0, 1, S_RUN)); // 17
    tbl.push_back(mk(0, 0, 0, 0, C_NOP, 0, 1, V_0,  0, 0, 0, S_RUN)); // 18 reset
    tbl.push_back(mk(1, 0, 0, 15, C_PC, 0, 1, V_DR, 0, 0, 0, S_RUN)); // 19 PC write in D
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_DR, 0, 0, 1, S_DR));  // 20 in E
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_DR, 0, 0, 2, S_DR));  // 21 in M
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_DR, 0, 0, 3, S_DR));  // 22 in W
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_0,  0, 0, 4, S_RUN)); // 23 redirected
    tbl.push_back(mk(1, 0, 0, 0, C_STR, 0, 1, V_0,  0, 0, 4, S_RUN)); // 24 STR
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_0,  0, 0, 4, S_RUN)); // 25 branch insn
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 1, 0, V_MW, 0, 0, 4, S_RUN)); // 26 wait 1
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 1, 0, V_MW, 0, 0, 5, S_MW));  // 27 wait 2
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 1, 0, V_MW, 0, 0, 6, S_MW));  // 28 wait 3
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 1, 1, V_BR, 0, 0, 7, S_MW));  // 29 held branch
    tbl.push_back(mk(1, 0, 0, 0, C_NOP, 0, 1, V_0,  0, 0, 7, S_RUN)); // 30

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d ctl", i),   16'(ctl_vec()),   16'(tbl[i].exp_ctl));
      chk($sformatf("row%0d fwd_a", i), 16'(fwd_a_e),     16'(tbl[i].exp_fa));
      chk($sformatf("row%0d fwd_b", i), 16'(fwd_b_e),     16'(tbl[i].exp_fb));
      chk($sformatf("row%0d cnt", i),   16'(stall_cnt),   16'(tbl[i].exp_cnt));
      chk($sformatf("row%0d state", i), 16'(dbg_state),   16'(tbl[i].exp_st));
    end

    // Long memory wait: counter climbs from 7 and saturates at 15.
    @(negedge clk);
    drive_nop(1'b0, 1'b1);
    {regwrite_d, memtoreg_d, pcsrc_d, memop_d} = 4'b0001;
    @(negedge clk);
    drive_nop(1'b0, 1'b1);
    @(negedge clk);
    drive_nop(1'b0, 1'b0);
    #1;
    chk("wait_entry ctl", 16'(ctl_vec()), 16'(V_MW));
    repeat (7) @(negedge clk);
    #1;
    chk("cnt_before_sat", 16'(stall_cnt), 16'd14);
    repeat (5) @(negedge clk);
    #1;
    chk("cnt_saturated", 16'(stall_cnt), 16'd15);
    chk("long_wait ctl", 16'(ctl_vec()), 16'(V_MW));
    chk("long_wait state", 16'(dbg_state), 16'(S_MW));

    // Asynchronous reset in the middle of the wait, away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst ctl", 16'(ctl_vec()), 16'(V_0));
    chk("async_rst cnt", 16'(stall_cnt), 16'd0);
    chk("async_rst state", 16'(dbg_state), 16'(S_RUN));
    chk("async_rst fwd", 16'({fwd_a_e, fwd_b_e}), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    drive_nop(1'b0, 1'b1);
    #1;
    chk("post_rst ctl", 16'(ctl_vec()), 16'(V_0));
    @(negedge clk);
    #1;
    chk("post_rst state", 16'(dbg_state), 16'(S_RUN));
    chk("post_rst cnt", 16'(stall_cnt), 16'd0);
    chk("post_rst ctl2", 16'(ctl_vec()), 16'(V_0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Sequences the pipeline registers, including the M/W register, through stall, flush and forward controls.
- Keeps its own shadow copy of E/M/W control fields (wa3, regwrite, memtoreg, pcsrc, memop, source regs) that advances in lock-step with the datapath registers.
- Decides forwarding, load-use stalls, branch flushes, PC-write drains and data-memory wait states.

Parameters:
- RA_W, 4, register address width (16 architectural regs, R15 = PC)
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ra1d, ra2d  in  RA_W  source regs of the instruction in D
- wa3d  in  RA_W  destination reg of the instruction in D
- regwrite_d, memtoreg_d, pcsrc_d, memop_d  in  1 each  D-stage controls
- branch_taken_e  in  1  conditional branch resolved taken in E
- mem_ready  in  1  data memory done this cycle
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register
- flush_d, flush_e, flush_w  out  1 each  load a bubble into D/E/W
- fwd_a_e, fwd_b_e  out  2 each  E operand select: 00 regfile, 01 W result, 10 M ALU out
- stall_cnt  out  CNT_W  saturating count of cycles with stall_f=1

Behaviour:
- Reset (reset=0, async): all shadow stages invalid; FSM=RUN; stall_cnt=0. All stall/flush outputs 0; fwd 00.
- Shadow pipeline: E<=D fields, M<=E, W<=M on each clk.
  - A stalled stage holds its contents.
  - A flushed stage loads valid=0.
  - An invalid stage never matches any hazard check.
- Forwarding (combinational), for each E source ra:
  - 10 if M valid & regwrite_m & wa3m==ra;
  - else 01 if W valid & regwrite_w & wa3w==ra;
  - else 00.
  - ra==4'hF is never forwarded; M beats W.
- Load-use: E valid & memtoreg_e & wa3e matches ra1d or ra2d (not R15) -> stall_f, stall_d, flush_e for exactly 1 cycle.
- Branch: branch_taken_e -> flush_d, flush_e. This overrides load-use in the same cycle (no stall).
- FSM states: RUN, DRAIN, MEM_WAIT.
  - RUN->DRAIN: a pcsrc_d instruction leaves D (D not stalled).
  - DRAIN->RUN: that instruction's pcsrc_w is seen in W.
  - DRAIN, and RUN while pcsrc_d is valid: stall_f=1, flush_d=1 until redirect.
  - Any state->MEM_WAIT: M valid & memop_m & !mem_ready. The previous state is saved.
  - MEM_WAIT: stall_f/d/e/m=1, flush_w=1, all other flushes suppressed.
  - MEM_WAIT exits on the cycle mem_ready=1, returning to the saved state. M advances that edge.
- Priority: reset > MEM_WAIT > branch > load-use > PC drain.
- A branch_taken_e held during MEM_WAIT takes effect on the first non-wait cycle.
- stall_cnt increments on every cycle with stall_f=1 and saturates at all-ones.
- Reset asserted mid-operation: immediate return to the reset state; the in-flight wait or drain is discarded.

Decomposition:
- Shared package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - hz_state_t enum (RUN, DRAIN, MEM_WAIT)
  - stage_ctl_t struct {valid, ra1, ra2, wa3, regwrite, memtoreg, pcsrc, memop}
  - PC_REG=4'hF
- One sub-module, hazard_fwd_sel: combinational match logic, instantiated once per E operand.

Test Plan:
- Forwarding:
  - ADD R1 in M (regwrite_m=1, wa3m=1), E reads ra1e=1 -> fwd_a_e=10.
  - Same R1 write only in W -> fwd_a_e=01.
  - ra1e=15 with a matching R15 write -> fwd_a_e=00.
- Load-use:
  - LDR R2 in E (memtoreg_e=1, wa3e=2), ra2d=2 -> stall_f=stall_d=flush_e=1 for 1 cycle.
  - Next cycle fwd_b_e=01 once the load is in W.
- Branch vs load-use: branch_taken_e=1 in the same cycle as a load-use match -> flush_d=flush_e=1, stall_d=0.
- PC drain: pcsrc_d=1 -> stall_f=1 for 4 consecutive cycles (D, E, M, W), RUN on the cycle after pcsrc_w; stall_cnt=4.
- Memory wait: memop_m=1, mem_ready=0 for 3 cycles -> stall_f/d/e/m=1 and flush_w=1 for 3 cycles, then resume; a held branch_taken_e flushes on cycle 4.
- Async reset: assert reset=0 in MEM_WAIT mid-cycle -> all outputs 0 immediately, stall_cnt=0; RUN after release.
